// File: rtl/stage_pkg.sv
// Shared widths, defaults and the verdict type for the GE pass/bonus chain.
package stage_pkg;

   localparam int unsigned EFFORT_W = 7;
   localparam int unsigned HARD_W   = 5;
   localparam int unsigned RAND_W   = 5;
   localparam int unsigned BONUS_W  = 2;
   localparam int unsigned SCORE_W  = 8;

   localparam logic [BONUS_W-1:0] BONUS_MAX = 2'd3;

   localparam int unsigned HARD_SHIFT_DEF   = 2;
   localparam int unsigned BONUS_MARGIN_DEF = 32;

   typedef struct packed {
      logic               pass;
      logic [BONUS_W-1:0] bonus;
   } verdict_t;

   // Bonus increment that sticks at BONUS_MAX instead of wrapping.
   function automatic logic [BONUS_W-1:0] bonus_sat_inc(input logic [BONUS_W-1:0] b);
      if (b == BONUS_MAX) return BONUS_MAX;
      return b + 1'b1;
   endfunction

endpackage

// File: rtl/stage_2_judge.sv
// Combinational stage-2 judgement: score vs. difficulty, next pass/bonus.
module stage_2_judge
   import stage_pkg::*;
#(
   parameter int unsigned HARD_SHIFT   = HARD_SHIFT_DEF,
   parameter int unsigned BONUS_MARGIN = BONUS_MARGIN_DEF
) (
   input  logic               pass1,
   input  logic [BONUS_W-1:0] bonus1,
   input  logic [EFFORT_W-1:0] effort,
   input  logic [HARD_W-1:0]  hard,
   input  logic [RAND_W-1:0]  random2,
   output logic               pass_next,
   output logic [BONUS_W-1:0] bonus_next
);

   logic [SCORE_W-1:0] score;
   logic [SCORE_W-1:0] need;
   logic [SCORE_W-1:0] margin;
   logic               ok;

   // Score, requirement and verdict; any failure clears the bonus.
   always_comb begin
      score      = SCORE_W'(effort) + SCORE_W'(random2);
      need       = SCORE_W'(hard) << HARD_SHIFT;
      ok         = pass1 && (score >= need);
      margin     = '0;
      pass_next  = 1'b0;
      bonus_next = '0;
      if (ok) begin
         margin    = score - need;
         pass_next = 1'b1;
         if (margin >= SCORE_W'(BONUS_MARGIN))
            bonus_next = bonus_sat_inc(bonus1);
         else
            bonus_next = bonus1;
      end
   end

endmodule

// File: rtl/stage_2.sv
// Stage 2 of the GE pass/bonus chain: registered verdict, 1-cycle latency.
module stage_2
   import stage_pkg::*;
#(
   parameter int unsigned HARD_SHIFT   = HARD_SHIFT_DEF,
   parameter int unsigned BONUS_MARGIN = BONUS_MARGIN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       pass1,
   input  logic [1:0] bonus1,
   input  logic [6:0] effort,
   input  logic [4:0] hard,
   input  logic [4:0] random2,
   output logic       out_valid,
   output logic       pass2,
   output logic [1:0] bonus2
);

   verdict_t result_d;
   verdict_t result_q;

   stage_2_judge #(
      .HARD_SHIFT   (HARD_SHIFT),
      .BONUS_MARGIN (BONUS_MARGIN)
   ) u_judge (
      .pass1      (pass1),
      .bonus1     (bonus1),
      .effort     (effort),
      .hard       (hard),
      .random2    (random2),
      .pass_next  (result_d.pass),
      .bonus_next (result_d.bonus)
   );

   // Valid strobe follows in_valid; the verdict only loads on a valid sample and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result_q  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) result_q <= result_d;
      end
   end

   assign pass2  = result_q.pass;
   assign bonus2 = result_q.bonus;

endmodule

// File: tb/tb_stage_2.sv
// Directed self-checking bench for stage_2.
module tb_stage_2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       pass1;
   logic [1:0] bonus1;
   logic [6:0] effort;
   logic [4:0] hard;
   logic [4:0] random2;
   logic       out_valid;
   logic       pass2;
   logic [1:0] bonus2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stage_2 #(
      .HARD_SHIFT   (2),
      .BONUS_MARGIN (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .pass1     (pass1),
      .bonus1    (bonus1),
      .effort    (effort),
      .hard      (hard),
      .random2   (random2),
      .out_valid (out_valid),
      .pass2     (pass2),
      .bonus2    (bonus2)
   );

   // Drive one valid sample; results are sampled 1 time unit after the next rising edge.
   task automatic apply(input logic p, input logic [1:0] b, input logic [6:0] e,
                        input logic [4:0] h, input logic [4:0] r);
      in_valid = 1'b1; pass1 = p; bonus1 = b; effort = e; hard = h; random2 = r;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_state;
      rst_n = 1'b0; in_valid = 1'b0; pass1 = 1'b0; bonus1 = 2'd0;
      effort = '0; hard = '0; random2 = '0;
      #3;
      checks++;
      if ({out_valid, pass2, bonus2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state: got v=%b p=%b b=%0d want v=0 p=0 b=0", out_valid, pass2, bonus2);
      end
      // Clock edges with a valid sample while held in reset must not load anything.
      apply(1'b1, 2'd1, 7'd100, 5'd0, 5'd0);
      step();
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_held: got v=%b p=%b b=%0d want v=0 p=0 b=0", out_valid, pass2, bonus2);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stage1_fail;
      apply(1'b0, 2'd2, 7'd127, 5'd0, 5'd31);
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL stage1_fail: got v=%b p=%b b=%0d want v=1 p=0 b=0", out_valid, pass2, bonus2);
      end
   endtask

   task automatic test_boundary;
      apply(1'b1, 2'd1, 7'd40, 5'd10, 5'd0);   // score 40 == need 40
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd1}) begin
         errors++;
         $display("FAIL boundary_pass: got v=%b p=%b b=%0d want v=1 p=1 b=1", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd1, 7'd39, 5'd10, 5'd0);   // score 39 < need 40
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL boundary_fail: got v=%b p=%b b=%0d want v=1 p=0 b=0", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd2, 7'd127, 5'd31, 5'd0);  // need 124, score 127, margin 3
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL max_hard_pass: got v=%b p=%b b=%0d want v=1 p=1 b=2", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd2, 7'd100, 5'd31, 5'd23); // score 123 < need 124
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL max_hard_fail: got v=%b p=%b b=%0d want v=1 p=0 b=0", out_valid, pass2, bonus2);
      end
   endtask

   task automatic test_bonus_margin;
      apply(1'b1, 2'd1, 7'd52, 5'd5, 5'd0);    // need 20, margin 32
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL margin_32: got v=%b p=%b b=%0d want v=1 p=1 b=2", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd1, 7'd51, 5'd5, 5'd0);    // margin 31, no bonus
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd1}) begin
         errors++;
         $display("FAIL margin_31: got v=%b p=%b b=%0d want v=1 p=1 b=1", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd3, 7'd100, 5'd5, 5'd31);  // score 131, margin 111, saturate
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd3}) begin
         errors++;
         $display("FAIL bonus_saturate: got v=%b p=%b b=%0d want v=1 p=1 b=3", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd2, 7'd30, 5'd0, 5'd2);    // need 0, margin 32, 2 -> 3
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd3}) begin
         errors++;
         $display("FAIL bonus_2_to_3: got v=%b p=%b b=%0d want v=1 p=1 b=3", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd0, 7'd0, 5'd0, 5'd0);     // 0 >= 0 passes, margin 0
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd0}) begin
         errors++;
         $display("FAIL zero_pass: got v=%b p=%b b=%0d want v=1 p=1 b=0", out_valid, pass2, bonus2);
      end
   endtask

   task automatic test_back_to_back;
      apply(1'b1, 2'd0, 7'd80, 5'd8, 5'd10);   // need 32, score 90, margin 58 -> b=1
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd1}) begin
         errors++;
         $display("FAIL b2b_first: got v=%b p=%b b=%0d want v=1 p=1 b=1", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd3, 7'd10, 5'd8, 5'd5);    // score 15 < 32
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL b2b_second: got v=%b p=%b b=%0d want v=1 p=0 b=0", out_valid, pass2, bonus2);
      end
      apply(1'b1, 2'd2, 7'd60, 5'd12, 5'd3);   // need 48, score 63, margin 15 -> b=2
      step();
      in_valid = 1'b0;
      pass1 = 1'b0; bonus1 = 2'd0; effort = '0; hard = 5'd31; random2 = '0;
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL b2b_third: got v=%b p=%b b=%0d want v=1 p=1 b=2", out_valid, pass2, bonus2);
      end
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b0, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL idle_hold: got v=%b p=%b b=%0d want v=0 p=1 b=2", out_valid, pass2, bonus2);
      end
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b0, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL idle_hold2: got v=%b p=%b b=%0d want v=0 p=1 b=2", out_valid, pass2, bonus2);
      end
   endtask

   task automatic test_reset_midop;
      apply(1'b1, 2'd1, 7'd90, 5'd2, 5'd0);    // margin 82 -> b=2
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd2}) begin
         errors++;
         $display("FAIL pre_reset: got v=%b p=%b b=%0d want v=1 p=1 b=2", out_valid, pass2, bonus2);
      end
      // Pending sample is on the inputs; reset lands mid-cycle before the edge.
      apply(1'b1, 2'd3, 7'd127, 5'd0, 5'd31);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, pass2, bonus2} !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset: got v=%b p=%b b=%0d want v=0 p=0 b=0", out_valid, pass2, bonus2);
      end
      step();
      checks++;
      if ({out_valid, pass2, bonus2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_discard: got v=%b p=%b b=%0d want v=0 p=0 b=0", out_valid, pass2, bonus2);
      end
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, 2'd0, 7'd45, 5'd11, 5'd0);   // need 44, margin 1 -> b=0
      step();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, pass2, bonus2} !== {1'b1, 1'b1, 2'd0}) begin
         errors++;
         $display("FAIL post_reset: got v=%b p=%b b=%0d want v=1 p=1 b=0", out_valid, pass2, bonus2);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_strobe: got v=%b want v=0", out_valid);
      end
   endtask

   initial begin
      test_reset_state();
      test_stage1_fail();
      test_boundary();
      test_bonus_margin();
      test_back_to_back();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stage_2.md
Name: stage_2

Overview:
- Second evaluation stage of the GE pass/bonus chain.
- Takes the stage-1 verdict (pass1, bonus1) and a stage-2 attempt (effort, hard, random2).
- Produces a registered stage-2 verdict (pass2, bonus2) one clock after a valid input.
- Sits directly after stage 1; its outputs feed the next stage unchanged.

Parameters:
- HARD_SHIFT, default 2: required score = hard << HARD_SHIFT (hard*4 at default).
- BONUS_MARGIN, default 32: minimum score surplus over the requirement that earns a bonus increment.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample qualifier
- pass1  in  1  stage-1 pass flag
- bonus1  in  2  stage-1 bonus count (0..3)
- effort  in  7  player effort (0..127)
- hard  in  5  stage difficulty (0..31)
- random2  in  5  random luck term (0..31)
- out_valid  out  1  one-cycle strobe, result valid
- pass2  out  1  stage-2 pass flag
- bonus2  out  2  stage-2 bonus count

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: out_valid=0, pass2=0, bonus2=0, regardless of clk.
  - Reset asserted mid-operation discards any pending sample; the first valid sample after release is accepted normally.
- Arithmetic (combinational, unsigned):
  - score = effort + random2, 8 bits, range 0..158.
  - need = hard << HARD_SHIFT, 8 bits, range 0..124.
  - ok = pass1 AND (score >= need).
  - margin = score - need, evaluated only when ok.
  - Compare is inclusive: score == need passes.
- Result:
  - ok=0 -> pass2=0, bonus2=0. Failing stage 1 or stage 2 clears the bonus.
  - ok=1 and margin < BONUS_MARGIN -> pass2=1, bonus2=bonus1.
  - ok=1 and margin >= BONUS_MARGIN -> pass2=1, bonus2=min(bonus1+1, 3). The increment saturates at 3 and never wraps to 0.
- Timing:
  - On a rising clk with in_valid=1, pass2/bonus2 load the result and out_valid=1 for the following cycle.
  - Latency is exactly 1 cycle.
  - Throughput is one sample per cycle; back-to-back in_valid is fully supported.
  - On a rising clk with in_valid=0, out_valid=0 and pass2/bonus2 hold their last values.
- No backpressure; no internal state beyond the output registers.
- No X propagation: all inputs are sampled only when in_valid=1.

Decomposition:
- Shared package stage_pkg:
  - width constants EFFORT_W=7, HARD_W=5, RAND_W=5, BONUS_W=2, SCORE_W=8.
  - BONUS_MAX=3.
  - default HARD_SHIFT and BONUS_MARGIN.
- One combinational sub-module, stage_2_judge, computes score/need/ok/margin and the next pass/bonus.
- stage_2 wraps stage_2_judge with the valid/output registers and reset.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle after a passing result -> out_valid=0, pass2=0, bonus2=0 immediately.
- Stage-1 fail: pass1=0, bonus1=2, effort=127, hard=0, random2=31, in_valid=1 -> next cycle out_valid=1, pass2=0, bonus2=0.
- Boundary pass: pass1=1, bonus1=1, effort=40, hard=10, random2=0 (score=need=40) -> pass2=1, bonus2=1.
- Boundary fail: pass1=1, bonus1=1, effort=39, hard=10, random2=0 -> pass2=0, bonus2=0.
- Bonus margin:
  - pass1=1, bonus1=1, effort=52, hard=5, random2=0 (margin 32) -> pass2=1, bonus2=2.
  - Same inputs with bonus1=3, effort=100, random2=31 -> pass2=1, bonus2=3 (saturated).
- Handshake: three back-to-back valid samples yield three consecutive out_valid pulses with matching results; then in_valid=0 -> out_valid=0 and pass2/bonus2 hold the third result.
